// File: rtl/led_bar_animator.sv
// LED bar animator: switch-selected speed and pattern, one frame per prescaler tick.
// Switch inputs are synchronised; a change of synchronised speed or mode restarts
// the frame period, and a mode change also restarts the animation from position 0.
module led_bar_animator #(
  parameter int unsigned LED_N       = 16,
  parameter int unsigned PER1        = 100000000,
  parameter int unsigned PER2        = 50000000,
  parameter int unsigned PER3        = 20000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   speed_sw,
  input  logic [1:0]                   mode_sw,
  output logic [LED_N-1:0]             leds,
  output logic [$clog2(LED_N+1)-1:0]   pos,
  output logic                         tick
);

  localparam int unsigned PosW   = $clog2(LED_N + 1);
  localparam int unsigned PerMax = (PER1 > PER2) ? ((PER1 > PER3) ? PER1 : PER3)
                                                 : ((PER2 > PER3) ? PER2 : PER3);
  localparam int unsigned CntW   = $clog2(PerMax);
  localparam int unsigned SyncW  = 2 * SYNC_STAGES;

  localparam logic [1:0] ModeBounce = 2'd0;
  localparam logic [1:0] ModeScan   = 2'd1;
  localparam logic [1:0] ModeWrap   = 2'd2;
  localparam logic [1:0] ModeHold   = 2'd3;

  localparam logic [LED_N-1:0] LedOnes = '1;
  localparam logic [LED_N-1:0] LedTop  = {1'b1, {(LED_N-1){1'b0}}};

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [SyncW-1:0] speed_sync_q, mode_sync_q;
  logic [1:0]       speed_s, speed_nx, mode_s, mode_nx;
  logic             speed_chg, mode_chg, run;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [PosW-1:0]  pos_q, pos_d, top;
  dir_e             dir_q, dir_d;
  logic [LED_N-1:0] leds_q, leds_d;

  // Last stage is the synchronised value; the stage before it is the value it takes
  // on the next edge, so a change is acted on in the same edge it becomes visible.
  assign speed_s   = speed_sync_q[SyncW-1 -: 2];
  assign speed_nx  = speed_sync_q[SyncW-3 -: 2];
  assign mode_s    = mode_sync_q[SyncW-1 -: 2];
  assign mode_nx   = mode_sync_q[SyncW-3 -: 2];
  assign speed_chg = (speed_s != speed_nx);
  assign mode_chg  = (mode_s != mode_nx);
  assign run       = (speed_s != 2'd0) && (mode_s != ModeHold);

  function automatic logic [CntW-1:0] reload_val(input logic [1:0] s);
    logic [CntW-1:0] v;
    unique case (s)
      2'd1:    v = CntW'(PER1 - 1);
      2'd2:    v = CntW'(PER2 - 1);
      2'd3:    v = CntW'(PER3 - 1);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [LED_N-1:0] pattern(input logic [1:0] m, input logic [PosW-1:0] p);
    return (m == ModeScan) ? (LedTop >> p) : ~(LedOnes >> p);
  endfunction

  // Switch synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_sync_q <= '0;
      mode_sync_q  <= '0;
    end else begin
      speed_sync_q <= {speed_sync_q[SyncW-3:0], speed_sw};
      mode_sync_q  <= {mode_sync_q[SyncW-3:0], mode_sw};
    end
  end

  // Prescaler next state: reload on any switch change, otherwise count down while running.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (speed_chg || mode_chg) begin
      cnt_d = reload_val(speed_nx);
    end else if (run) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        cnt_d  = reload_val(speed_s);
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Frame next state: mode change restarts, otherwise advance at the end of a tick cycle.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    leds_d = leds_q;
    top    = (mode_s == ModeScan) ? PosW'(LED_N - 1) : PosW'(LED_N);
    if (mode_chg) begin
      pos_d = '0;
      dir_d = DirUp;
      // Hold keeps whatever was on display.
      if (mode_nx != ModeHold) leds_d = pattern(mode_nx, '0);
    end else if (tick_q && (mode_s != ModeHold)) begin
      unique case (mode_s)
        ModeWrap: pos_d = (pos_q == top) ? '0 : pos_q + PosW'(1);
        default: begin
          if (dir_q == DirUp) begin
            if (pos_q == top) begin
              pos_d = top - PosW'(1);
              dir_d = DirDown;
            end else begin
              pos_d = pos_q + PosW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = PosW'(1);
              dir_d = DirUp;
            end else begin
              pos_d = pos_q - PosW'(1);
            end
          end
        end
      endcase
      leds_d = pattern(mode_s, pos_d);
    end
  end

  // Prescaler and frame state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pos_q  <= '0;
      dir_q  <= DirUp;
      leds_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;
  assign pos  = pos_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_bar_animator.sv
// Bench for led_bar_animator: directed scenarios plus random switch activity, all
// checked against a frame-index reference model.
module tb_led_bar_animator;

  localparam int N  = 4;
  localparam int P1 = 8;
  localparam int P2 = 4;
  localparam int P3 = 2;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   speed_sw = 2'd0;
  logic [1:0]   mode_sw = 2'd0;
  logic [N-1:0] leds;
  logic [2:0]   pos;
  logic         tick;

  int checks = 0;
  int failures = 0;

  // Reference model: synchroniser pipes, frame index within the mode's cycle,
  // cycles remaining until the next tick.
  int m_sp [SS];
  int m_md [SS];
  int m_k, m_pos, m_leds, m_tick, m_remain;

  always #5 clk = ~clk;

  led_bar_animator #(
    .LED_N(N), .PER1(P1), .PER2(P2), .PER3(P3), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .speed_sw(speed_sw), .mode_sw(mode_sw),
    .leds(leds), .pos(pos), .tick(tick)
  );

  function automatic int per_of(input int s);
    return (s == 1) ? P1 : (s == 2) ? P2 : (s == 3) ? P3 : 0;
  endfunction

  function automatic int period_of(input int m);
    return (m == 0) ? 2 * N : (m == 1) ? 2 * N - 2 : (m == 2) ? N + 1 : 1;
  endfunction

  function automatic int pos_of(input int m, input int k);
    if (m == 0) return (k <= N) ? k : 2 * N - k;
    if (m == 1) return (k <= N - 1) ? k : 2 * N - 2 - k;
    if (m == 2) return k;
    return 0;
  endfunction

  function automatic int pat_of(input int m, input int p);
    if (m == 1) return 1 << (N - 1 - p);
    return ((1 << p) - 1) << (N - p);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) begin
      m_sp[i] = 0;
      m_md[i] = 0;
    end
    m_k = 0; m_pos = 0; m_leds = 0; m_tick = 0; m_remain = 0;
  endtask

  task automatic model_edge();
    int old_sp, new_sp, old_md, new_md, tick_before;
    old_sp = m_sp[SS-1]; new_sp = m_sp[SS-2];
    old_md = m_md[SS-1]; new_md = m_md[SS-2];
    tick_before = m_tick;
    if (old_md != new_md) begin
      m_k = 0;
      m_pos = 0;
      if (new_md != 3) m_leds = pat_of(new_md, 0);
    end else if (tick_before == 1) begin
      m_k = (m_k + 1) % period_of(old_md);
      m_pos = pos_of(old_md, m_k);
      m_leds = pat_of(old_md, m_pos);
    end
    if (old_sp != new_sp || old_md != new_md) begin
      m_remain = per_of(new_sp);
      m_tick = 0;
    end else if (old_sp != 0 && old_md != 3) begin
      m_remain--;
      if (m_remain == 0) begin
        m_tick = 1;
        m_remain = per_of(old_sp);
      end else begin
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
    for (int i = SS - 1; i > 0; i--) begin
      m_sp[i] = m_sp[i-1];
      m_md[i] = m_md[i-1];
    end
    m_sp[0] = int'(speed_sw);
    m_md[0] = int'(mode_sw);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", 32'(tick), m_tick);
    chk("leds", 32'(leds), m_leds);
    chk("pos", 32'(pos), m_pos);
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_leds", 32'(leds), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_pos", 32'(pos), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for each model tick, then compare the following frame with a fixed table.
  task automatic check_frames(input string tag, input int seq [9], input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (m_tick != 1 && w < 40) begin
        step();
        w++;
      end
      if (m_tick != 1) bound_fail(tag);
      step();
      chk($sformatf("%s[%0d]", tag, i), 32'(leds), seq[i]);
    end
  endtask

  task automatic wait_state(input string tag, input int l, input int t);
    int w = 0;
    while (!(m_leds == l && m_tick == t) && w < 40) begin
      step();
      w++;
    end
    if (!(m_leds == l && m_tick == t)) bound_fail(tag);
  endtask

  task automatic cycles_to_tick(input string tag, input int exp);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (tick === 1'b1) seen = 1;
    end
    chk(tag, n, exp);
  endtask

  int seq_bounce [9] = '{8, 12, 14, 15, 14, 12, 8, 0, 8};
  int seq_scan   [9] = '{4, 2, 1, 2, 4, 8, 0, 0, 0};
  int seq_wrap   [9] = '{8, 12, 14, 15, 0, 0, 0, 0, 0};

  initial begin
    model_reset();
    #12;
    chk("reset_leds", 32'(leds), 0);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_pos", 32'(pos), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stopped after reset.
    repeat (4) step();

    // Fill-bounce at speed 3.
    speed_sw = 2'd3;
    check_frames("bounce", seq_bounce, 9);

    // Dot-scanner.
    mode_sw = 2'd1;
    repeat (SS) step();
    chk("scan_start_leds", 32'(leds), 8);
    chk("scan_start_pos", 32'(pos), 0);
    check_frames("scan", seq_scan, 6);

    // Fill-wrap.
    mode_sw = 2'd2;
    repeat (SS) step();
    chk("wrap_start_leds", 32'(leds), 0);
    check_frames("wrap", seq_wrap, 5);

    // Stop at 1100, hold, resume.
    mode_sw = 2'd0;
    repeat (SS) step();
    wait_state("wait_1000", 8, 1);
    speed_sw = 2'd0;
    repeat (SS) step();
    chk("stop_leds", 32'(leds), 12);
    repeat (50) step();
    chk("stop_hold_leds", 32'(leds), 12);
    speed_sw = 2'd3;
    cycles_to_tick("resume_latency", SS + P3);
    step();
    chk("resume_leds", 32'(leds), 14);

    // Mode change on the edge that ends a tick cycle at 1110.
    mode_sw = 2'd1;
    step();
    chk("coinc_tick", 32'(tick), 1);
    chk("coinc_leds_before", 32'(leds), 14);
    step();
    chk("coinc_leds_after", 32'(leds), 8);
    chk("coinc_pos_after", 32'(pos), 0);

    // Speed 1 -> 2 mid-period.
    mode_sw = 2'd0;
    speed_sw = 2'd1;
    begin
      int w = 0;
      while (m_tick != 1 && w < 40) begin
        step();
        w++;
      end
      if (m_tick != 1) bound_fail("speed1_tick");
    end
    repeat (3) step();
    speed_sw = 2'd2;
    cycles_to_tick("speed_change_latency", SS + P2);

    // Asynchronous reset mid-run; speed stays selected through it.
    do_reset();
    step();
    chk("post_reset_leds", 32'(leds), 0);
    step();
    chk("post_reset_leds2", 32'(leds), 0);
    chk("post_reset_tick2", 32'(tick), 0);

    // Random switch activity with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) speed_sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 23) == 0) mode_sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
